decode_seq: RTL and testbench

Parametrised, multi-step instruction decoder for the scd core. It accepts one opcode per valid/ready handshake and emits registered ALU and control flag words for one or more execute steps per instruction. Multi-step operations (ldb) sequence through their steps internally. Sits between the fetch/instruction register and the datapath. It supports stall, flush, and illegal-opcode flagging, which the earlier pure-combinational decode could not.

---
 rtl/decode_seq.sv | 196 +++++++++++++++++++
 tb/tb_decode_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/decode_seq.sv
// decode_seq: multi-step instruction decoder for the scd core.
// Accepts one opcode per valid/ready handshake. For each execute step it
// presents registered ALU and datapath control flag words. Multi-step
// opcodes (ldb) sequence through their steps internally. The decoder also
// supports stall (hold the current step), flush (abort the instruction) and
// flagging of undefined opcodes.
module decode_seq #(
    parameter int OPC_W     = 4,
    parameter int FLAG_W    = 8,
    parameter int MAX_STEPS = 2,
    localparam int STEP_W   = (MAX_STEPS > 2) ? $clog2(MAX_STEPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [FLAG_W-1:0] alu_flags,
    output logic [FLAG_W-1:0] ctrl_flags,
    output logic [STEP_W-1:0] step,
    output logic              last,
    output logic              illegal
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_NOR = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_SRL = 4'h5;
    localparam logic [3:0] OP_SRA = 4'h6;
    localparam logic [3:0] OP_JLR = 4'h7;
    localparam logic [3:0] OP_JLI = 4'h8;
    localparam logic [3:0] OP_BCC = 4'h9;
    localparam logic [3:0] OP_ADI = 4'hC;
    localparam logic [3:0] OP_STB = 4'hD;
    localparam logic [3:0] OP_LDB = 4'hE;
    localparam logic [3:0] OP_LDI = 4'hF;

    // Decoded step record: {illegal, last, alu[7:0], ctrl[7:0]}
    localparam int DEC_W = 18;

    logic [0:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic [7:0]        alu_q, alu_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic              last_q, last_d;
    logic              ill_q, ill_d;

    logic              accept;
    logic [DEC_W-1:0]  dec_new;
    logic [DEC_W-1:0]  dec_next;

    // Flag program for one step of an opcode. 'first' selects step 0;
    // only ldb has a second step, so any later step decodes as step 1.
    function automatic logic [DEC_W-1:0] decode_step(
        input logic [OPC_W-1:0] opc,
        input logic             first
    );
        logic [7:0] alu;
        logic [7:0] ctrl;
        logic       lst;
        logic       ill;
        alu  = 8'h00;
        ctrl = 8'h00;
        lst  = 1'b1;
        ill  = 1'b0;
        if (|(opc >> 4)) begin
            // Opcodes beyond the 4-bit space are undefined
            ill = 1'b1;
        end else begin
            case (opc[3:0])
                OP_ADD: alu = 8'h00;
                OP_SUB: alu = 8'hC0;
                OP_XOR: alu = 8'h20;
                OP_NOR: alu = 8'h2C;
                OP_AND: alu = 8'h7C;
                OP_SRL: alu = 8'h02;
                OP_SRA: alu = 8'h03;
                OP_JLR: ctrl = 8'h18;
                OP_JLI: ctrl = 8'h28;
                OP_BCC: ctrl = 8'hA0;
                OP_ADI: ctrl = 8'h40;
                OP_STB: ctrl = 8'h04;
                OP_LDB: begin
                    if (first) begin
                        ctrl = 8'h02;  // memory read
                        lst  = 1'b0;
                    end else begin
                        ctrl = 8'h01;  // register load
                    end
                end
                OP_LDI: ctrl = 8'h01;
                default: ill = 1'b1;  // 0xA, 0xB
            endcase
        end
        return {ill, lst, alu, ctrl};
    endfunction

    // Handshake: a new opcode is taken when idle, or when the final step
    // of the current instruction is completing; flush blocks acceptance.
    always_comb begin
        in_ready = !flush && ((state_q == ST_IDLE) ||
                              ((state_q == ST_EXEC) && last_q && !stall));
        accept   = in_valid && in_ready;
    end

    // Decode the incoming opcode's first step and the held opcode's next step
    always_comb begin
        dec_new  = decode_step(opcode, 1'b1);
        dec_next = decode_step(opc_q, 1'b0);
    end

    // Next-state sequencing: flush > accept > step advance / retire > hold
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        opc_d   = opc_q;
        alu_d   = alu_q;
        ctrl_d  = ctrl_q;
        last_d  = last_q;
        ill_d   = ill_q;
        if (flush) begin
            state_d = ST_IDLE;
            step_d  = '0;
            opc_d   = '0;
            alu_d   = 8'h00;
            ctrl_d  = 8'h00;
            last_d  = 1'b0;
            ill_d   = 1'b0;
        end else if (accept) begin
            state_d = ST_EXEC;
            step_d  = '0;
            opc_d   = opcode;
            ill_d   = dec_new[17];
            last_d  = dec_new[16];
            alu_d   = dec_new[15:8];
            ctrl_d  = dec_new[7:0];
        end else if ((state_q == ST_EXEC) && !stall) begin
            if (!last_q) begin
                step_d = step_q + STEP_W'(1);
                ill_d  = dec_next[17];
                last_d = dec_next[16];
                alu_d  = dec_next[15:8];
                ctrl_d = dec_next[7:0];
            end else begin
                state_d = ST_IDLE;
                step_d  = '0;
                opc_d   = '0;
                alu_d   = 8'h00;
                ctrl_d  = 8'h00;
                last_d  = 1'b0;
                ill_d   = 1'b0;
            end
        end
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            opc_q   <= '0;
            alu_q   <= 8'h00;
            ctrl_q  <= 8'h00;
            last_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            opc_q   <= opc_d;
            alu_q   <= alu_d;
            ctrl_q  <= ctrl_d;
            last_q  <= last_d;
            ill_q   <= ill_d;
        end
    end

    // Outputs straight from registers; flag words zero-extended to FLAG_W
    always_comb begin
        out_valid  = (state_q == ST_EXEC);
        alu_flags  = FLAG_W'(alu_q);
        ctrl_flags = FLAG_W'(ctrl_q);
        step       = step_q;
        last       = last_q;
        illegal    = ill_q;
    end

endmodule

// File: tb/tb_decode_seq.sv
// Testbench for decode_seq: table-driven cycle vectors plus hand-written
// sequences for async reset mid-ldb and a 5-bit opcode instance.
module tb_decode_seq;

    logic       clk;
    logic       rst;

    // Main instance: OPC_W=4, FLAG_W=8
    logic       in_valid, in_ready, stall, flush;
    logic [3:0] opcode;
    logic       out_valid, last, illegal;
    logic [7:0] alu_flags, ctrl_flags;
    logic [0:0] step;

    // Second instance: OPC_W=5, FLAG_W=12
    logic        in_valid5, in_ready5;
    logic [4:0]  opcode5;
    logic        out_valid5, last5, illegal5;
    logic [11:0] alu_flags5, ctrl_flags5;
    logic [0:0]  step5;

    int n_checks = 0;
    int n_pass   = 0;

    decode_seq #(.OPC_W(4), .FLAG_W(8), .MAX_STEPS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .stall(stall), .flush(flush), .out_valid(out_valid),
        .alu_flags(alu_flags), .ctrl_flags(ctrl_flags), .step(step),
        .last(last), .illegal(illegal)
    );

    decode_seq #(.OPC_W(5), .FLAG_W(12), .MAX_STEPS(2)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .opcode(opcode5), .stall(1'b0), .flush(1'b0), .out_valid(out_valid5),
        .alu_flags(alu_flags5), .ctrl_flags(ctrl_flags5), .step(step5),
        .last(last5), .illegal(illegal5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  opc;
        logic        st;
        logic        fl;
        logic        rdy;   // in_ready expected before the edge
        logic [19:0] exp;   // {out_valid, alu, ctrl, step, last, illegal} after the edge
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [3:0] opc,
                                input logic st, input logic fl, input logic rdy,
                                input logic ov, input logic [7:0] alu,
                                input logic [7:0] ctrl, input logic stp,
                                input logic lst, input logic ill);
        vec_t r;
        r.v = v; r.opc = opc; r.st = st; r.fl = fl; r.rdy = rdy;
        r.exp = {ov, alu, ctrl, stp, lst, ill};
        return r;
    endfunction

    function automatic logic [19:0] outs();
        return {out_valid, alu_flags, ctrl_flags, step, last, illegal};
    endfunction

    function automatic logic [27:0] outs5();
        return {out_valid5, alu_flags5, ctrl_flags5, step5, last5, illegal5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    vec_t vecs[29];

    initial begin
        //          v  opc   st fl rdy  ov alu    ctrl   s  l  i
        vecs[0]  = mk(1, 4'h0, 0, 0, 1,  1, 8'h00, 8'h00, 0, 1, 0);
        vecs[1]  = mk(1, 4'h1, 0, 0, 1,  1, 8'hC0, 8'h00, 0, 1, 0);
        vecs[2]  = mk(1, 4'h2, 0, 0, 1,  1, 8'h20, 8'h00, 0, 1, 0);
        vecs[3]  = mk(1, 4'h3, 0, 0, 1,  1, 8'h2C, 8'h00, 0, 1, 0);
        vecs[4]  = mk(1, 4'h4, 0, 0, 1,  1, 8'h7C, 8'h00, 0, 1, 0);
        vecs[5]  = mk(1, 4'h5, 0, 0, 1,  1, 8'h02, 8'h00, 0, 1, 0);
        vecs[6]  = mk(1, 4'h6, 0, 0, 1,  1, 8'h03, 8'h00, 0, 1, 0);
        // ldb followed by add with in_valid held
        vecs[7]  = mk(1, 4'hE, 0, 0, 1,  1, 8'h00, 8'h02, 0, 0, 0);
        vecs[8]  = mk(1, 4'h0, 0, 0, 0,  1, 8'h00, 8'h01, 1, 1, 0);
        vecs[9]  = mk(1, 4'h0, 0, 0, 1,  1, 8'h00, 8'h00, 0, 1, 0);
        // ldb with 3 stalled cycles in step 0
        vecs[10] = mk(1, 4'hE, 0, 0, 1,  1, 8'h00, 8'h02, 0, 0, 0);
        vecs[11] = mk(0, 4'h0, 1, 0, 0,  1, 8'h00, 8'h02, 0, 0, 0);
        vecs[12] = mk(0, 4'h0, 1, 0, 0,  1, 8'h00, 8'h02, 0, 0, 0);
        vecs[13] = mk(0, 4'h0, 1, 0, 0,  1, 8'h00, 8'h02, 0, 0, 0);
        vecs[14] = mk(0, 4'h0, 0, 0, 0,  1, 8'h00, 8'h01, 1, 1, 0);
        vecs[15] = mk(0, 4'h0, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0, 0);
        // illegal 0xA, then ldi
        vecs[16] = mk(1, 4'hA, 0, 0, 1,  1, 8'h00, 8'h00, 0, 1, 1);
        vecs[17] = mk(1, 4'hF, 0, 0, 1,  1, 8'h00, 8'h01, 0, 1, 0);
        // flush during ldb step 0 with sub offered, sub taken afterwards
        vecs[18] = mk(1, 4'hE, 0, 0, 1,  1, 8'h00, 8'h02, 0, 0, 0);
        vecs[19] = mk(1, 4'h1, 0, 1, 0,  0, 8'h00, 8'h00, 0, 0, 0);
        vecs[20] = mk(1, 4'h1, 0, 0, 1,  1, 8'hC0, 8'h00, 0, 1, 0);
        // accept under stall from IDLE, stall holds a last step
        vecs[21] = mk(0, 4'h0, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0, 0);
        vecs[22] = mk(1, 4'h7, 1, 0, 1,  1, 8'h00, 8'h18, 0, 1, 0);
        vecs[23] = mk(1, 4'h8, 1, 0, 0,  1, 8'h00, 8'h18, 0, 1, 0);
        vecs[24] = mk(1, 4'h9, 0, 0, 1,  1, 8'h00, 8'hA0, 0, 1, 0);
        vecs[25] = mk(1, 4'hC, 0, 0, 1,  1, 8'h00, 8'h40, 0, 1, 0);
        vecs[26] = mk(1, 4'hD, 0, 0, 1,  1, 8'h00, 8'h04, 0, 1, 0);
        vecs[27] = mk(0, 4'h0, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0, 0);
        // flush in IDLE with in_valid: nothing accepted
        vecs[28] = mk(1, 4'h3, 0, 1, 0,  0, 8'h00, 8'h00, 0, 0, 0);

        rst = 1'b1;
        in_valid = 1'b0; opcode = 4'h0; stall = 1'b0; flush = 1'b0;
        in_valid5 = 1'b0; opcode5 = 5'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs()), 32'h0);
        check("reset_outs5", 32'(outs5()), 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(in_ready), 32'h1);

        for (int i = 0; i < 29; i++) begin
            in_valid = vecs[i].v;
            opcode   = vecs[i].opc;
            stall    = vecs[i].st;
            flush    = vecs[i].fl;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
        end
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;

        // Async reset during ldb step 1
        in_valid = 1'b1; opcode = 4'hE;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("ldb_step1_before_rst", 32'(outs()), 32'({1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0}));
        #2 rst = 1'b1;
        #1;
        check("async_rst_clears", 32'(outs()), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready_after_async_rst", 32'(in_ready), 32'h1);
        in_valid = 1'b1; opcode = 4'h8;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("jli_after_rst", 32'(outs()), 32'({1'b1, 8'h00, 8'h28, 1'b0, 1'b1, 1'b0}));

        // 5-bit opcode instance: 0x13 illegal, then ldi legal, 12-bit flags
        in_valid5 = 1'b1; opcode5 = 5'h13;
        #1;
        check("w5_ready", 32'(in_ready5), 32'h1);
        @(posedge clk); #1;
        check("w5_op13_illegal", 32'(outs5()), 32'({1'b1, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1}));
        opcode5 = 5'h0F;
        @(posedge clk); #1;
        check("w5_ldi", 32'(outs5()), 32'({1'b1, 12'h000, 12'h001, 1'b0, 1'b1, 1'b0}));
        opcode5 = 5'h01;
        @(posedge clk); #1;
        check("w5_sub_zero_ext", 32'(outs5()), 32'({1'b1, 12'h0C0, 12'h000, 1'b0, 1'b1, 1'b0}));
        in_valid5 = 1'b0;
        @(posedge clk); #1;
        check("w5_idle", 32'(outs5()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
